// File: rtl/rob_tid_sched_pkg.sv
// Shared definitions for the read-ROB transaction-ID scheduler.
// Holds the legacy sizing constants (TID_MAX / FIFO_SIZE / AXI_ID_WIDTH),
// the default tID typedef and the scheduler FSM state encoding.
package rob_tid_sched_pkg;

  localparam int TID_MAX       = 16;
  localparam int FIFO_SIZE     = 8;
  localparam int AXI_ID_WIDTH  = 4;
  localparam int TID_WIDTH_DEF = $clog2(TID_MAX);

  typedef logic [TID_WIDTH_DEF-1:0] tid_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rob_tid_sched_id_table.sv
// rob_id_table: DEPTH x ID_WIDTH register file holding the ARID of every
// outstanding tID. One synchronous write port, one asynchronous read port,
// asynchronously cleared to 0.
// Ports:
//   clk, rst  clock / async active-high reset
//   i_we      write enable
//   i_waddr   write index
//   i_wdata   ARID to store
//   i_raddr   read index
//   o_rdata   ARID at i_raddr (combinational)
module rob_id_table #(
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [ID_WIDTH-1:0]      i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [ID_WIDTH-1:0]      o_rdata
);

  logic [ID_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rob_tid_sched.sv
// rob_tid_sched: stamps each accepted AXI read request with a sequential tID,
// records its ARID, limits outstanding requests to MAX_OUT and returns the
// ARID for each tID retired by the ROB. A flush drains all outstanding
// requests and restarts tID numbering at 0.
// Optional build macro: ROB_TID_CHECK_EN enables the sticky retire-order
// error (err_o); without it err_o is tied 0.
// Ports:
//   clk, rst                         clock / async active-high reset
//   req_valid_i/req_ready_o/req_id_i AR request handshake and ARID
//   issue_valid_o/issue_ready_i      stamped request toward tag compare
//   issue_tid_o/issue_id_o           assigned tID and passed-through ARID
//   retire_valid_i/retire_tid_i      ROB output handshake and its tID
//   retire_id_o                      ARID for retire_tid_i (combinational)
//   flush_i/flush_done_o             drain request / completion pulse
//   outstanding_o                    outstanding tID count
//   err_o                            sticky retire-order error
module rob_tid_sched
  import rob_tid_sched_pkg::*;
#(
  parameter int ID_WIDTH  = AXI_ID_WIDTH,
  parameter int TID_WIDTH = TID_WIDTH_DEF,
  parameter int MAX_OUT   = FIFO_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ID_WIDTH-1:0]        req_id_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [TID_WIDTH-1:0]       issue_tid_o,
  output logic [ID_WIDTH-1:0]        issue_id_o,
  input  logic                       retire_valid_i,
  input  logic [TID_WIDTH-1:0]       retire_tid_i,
  output logic [ID_WIDTH-1:0]        retire_id_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic [$clog2(MAX_OUT):0]   outstanding_o,
  output logic                       err_o
);

  localparam int AW = $clog2(MAX_OUT);
  localparam int CW = AW + 1;

  state_t                r_state;
  logic [TID_WIDTH-1:0]  r_head;
  logic [TID_WIDTH-1:0]  r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_issue_valid;
  logic [TID_WIDTH-1:0]  r_issue_tid;
  logic [ID_WIDTH-1:0]   r_issue_id;
  logic                  r_flush_done;
  logic                  r_flush_blk;
  logic                  r_err;

  logic                  w_flush_req;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_retire;
  logic                  w_drained;
  logic [TID_WIDTH-1:0]  w_head_next;
  logic                  w_err_set;

  // After a completed drain a still-asserted flush_i is masked until it has
  // been seen low, so one long flush level cannot trigger back-to-back drains.
  assign w_flush_req = (r_state == S_RUN) & flush_i & ~r_flush_blk;

  // Credit check uses the registered count only: a same-cycle retire does
  // not free a slot until the following cycle.
  assign w_ready  = (r_state == S_RUN) & ~w_flush_req
                  & (r_count < CW'(MAX_OUT))
                  & (~r_issue_valid | issue_ready_i);
  assign w_accept = req_valid_i & w_ready;
  assign w_retire = retire_valid_i & (r_count != '0);
  assign w_drained = (r_state == S_DRAIN) & (r_count == '0) & ~r_issue_valid;

`ifdef ROB_TID_CHECK_EN
  always_comb begin
    w_head_next = retire_tid_i + TID_WIDTH'(1);
    w_err_set   = retire_valid_i & ((retire_tid_i != r_head) | (r_count == '0));
  end
`else
  logic w_unused_tid;
  assign w_unused_tid = ^retire_tid_i;
  always_comb begin
    w_head_next = r_head + TID_WIDTH'(1);
    w_err_set   = 1'b0;
  end
`endif

  rob_id_table #(
    .DEPTH    (MAX_OUT),
    .ID_WIDTH (ID_WIDTH)
  ) u_id_table (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept),
    .i_waddr (r_tail[AW-1:0]),
    .i_wdata (req_id_i),
    .i_raddr (retire_tid_i[AW-1:0]),
    .o_rdata (retire_id_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_issue_valid <= 1'b0;
      r_issue_tid   <= '0;
      r_issue_id    <= '0;
      r_flush_done  <= 1'b0;
      r_flush_blk   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Issue register
      if (w_accept) begin
        r_issue_valid <= 1'b1;
        r_issue_tid   <= r_tail;
        r_issue_id    <= req_id_i;
      end else if (issue_ready_i) begin
        r_issue_valid <= 1'b0;
      end

      // Outstanding count
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // tID pointers; a completed drain restarts numbering at 0
      if (w_drained) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_accept) r_tail <= r_tail + TID_WIDTH'(1);
        if (w_retire) r_head <= w_head_next;
      end

      if (w_err_set) r_err <= 1'b1;

      r_flush_done <= w_drained;

      if (w_drained)     r_flush_blk <= 1'b1;
      else if (!flush_i) r_flush_blk <= 1'b0;

      case (r_state)
        S_RUN:   if (w_flush_req) r_state <= S_DRAIN;
        S_DRAIN: if (w_drained)   r_state <= S_DONE;
        S_DONE:  r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign req_ready_o   = w_ready;
  assign issue_valid_o = r_issue_valid;
  assign issue_tid_o   = r_issue_tid;
  assign issue_id_o    = r_issue_id;
  assign flush_done_o  = r_flush_done;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule
